// File: rtl/io_timer_intr.sv
// io_timer_intr: memory-mapped down-counting timer with a three-state
// interrupt handshake (IDLE -> REQ -> ACKD) and a sticky overflow flag.
// Registers at ADDR_BASE[11:4]: +0 CTRL, +4 LOAD, +8 COUNT, +C STATUS.
`timescale 1ns/1ps
module io_timer_intr #(
   parameter logic [11:0] ADDR_BASE = 12'h100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        io_cs,
   input  logic        io_rd,
   input  logic        io_wr,
   input  logic [31:0] addr,
   input  logic [31:0] D_in_IO,
   output logic [31:0] D_out_IO,
   output logic        intr,
   input  logic        int_ack
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ACKD = 2'd2
   } state_t;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_LOAD   = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   // architectural state
   logic        en_q,    en_d;
   logic        auto_q,  auto_d;
   logic [31:0] load_q,  load_d;
   logic [31:0] count_q, count_d;
   logic        ovf_q,   ovf_d;
   state_t      state_q;
   logic        intr_q;

   // bus decode
   logic        sel;
   logic        wr_en;
   logic        rd_en;
   logic        wr_ctrl;
   logic        wr_load;
   logic        wr_status;
   logic        evt;
   logic [31:0] rd_data;

   // only addr[11:4] selects the block and addr[3:2] the register
   logic unused_addr;
   assign unused_addr = ^{addr[31:12], addr[1:0]};

   assign sel       = io_cs && (addr[11:4] == ADDR_BASE[11:4]);
   assign wr_en     = sel && io_wr;
   assign rd_en     = sel && io_rd;
   assign wr_ctrl   = wr_en && (addr[3:2] == REG_CTRL);
   assign wr_load   = wr_en && (addr[3:2] == REG_LOAD);
   assign wr_status = wr_en && (addr[3:2] == REG_STATUS);

   // a terminal count of 1 while enabled is the one and only timer event
   assign evt = en_q && (count_q == 32'd1);

   // next-state for CTRL, LOAD and COUNT; a CTRL write overrides the
   // event's own effect on EN, and reloads always use the pre-write LOAD
   always_comb begin
      en_d    = en_q;
      auto_d  = auto_q;
      load_d  = load_q;
      count_d = count_q;

      if (en_q) begin
         if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
         end else if (count_q == 32'd1) begin
            if (auto_q) begin
               count_d = load_q;
            end else begin
               count_d = 32'd0;
               en_d    = 1'b0;
            end
         end
      end

      if (wr_ctrl) begin
         en_d   = D_in_IO[0];
         auto_d = D_in_IO[1];
         if (!en_q && D_in_IO[0]) begin
            count_d = load_q;
         end
      end

      if (wr_load) begin
         load_d = D_in_IO;
      end
   end

   // sticky overflow: a new overflow beats a simultaneous write-1-clear
   always_comb begin
      ovf_d = ovf_q;
      if (wr_status && D_in_IO[1]) begin
         ovf_d = 1'b0;
      end
      if (evt && (state_q != ST_IDLE)) begin
         ovf_d = 1'b1;
      end
   end

   // timer and configuration registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         en_q    <= 1'b0;
         auto_q  <= 1'b0;
         load_q  <= 32'd0;
         count_q <= 32'd0;
         ovf_q   <= 1'b0;
      end else begin
         en_q    <= en_d;
         auto_q  <= auto_d;
         load_q  <= load_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // interrupt handshake FSM with intr registered alongside the state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         intr_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (evt) begin
                  state_q <= ST_REQ;
                  intr_q  <= 1'b1;
               end
            end
            ST_REQ: begin
               if (int_ack) begin
                  state_q <= ST_ACKD;
                  intr_q  <= 1'b0;
               end
            end
            ST_ACKD: begin
               if (!int_ack) begin
                  state_q <= ST_IDLE;
                  intr_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               intr_q  <= 1'b0;
            end
         endcase
      end
   end

   // combinational read mux
   always_comb begin
      rd_data = 32'd0;
      case (addr[3:2])
         REG_CTRL:   rd_data = {30'd0, auto_q, en_q};
         REG_LOAD:   rd_data = load_q;
         REG_COUNT:  rd_data = count_q;
         REG_STATUS: rd_data = {30'd0, ovf_q, intr_q};
         default:    rd_data = 32'd0;
      endcase
   end

   assign D_out_IO = rd_en ? rd_data : 32'hzzzz_zzzz;
   assign intr     = intr_q;

endmodule

// File: tb/tb_io_timer_intr.sv
// tb_io_timer_intr: directed table of bus cycles for io_timer_intr, followed
// by hand-written sequences for async reset and same-edge collisions.
`timescale 1ns/1ps
module tb_io_timer_intr;

   localparam logic [11:0] CT = 12'h100;
   localparam logic [11:0] LD = 12'h104;
   localparam logic [11:0] CN = 12'h108;
   localparam logic [11:0] ST = 12'h10C;

   logic        clk = 1'b0;
   logic        reset;
   logic        io_cs, io_rd, io_wr, int_ack;
   logic [31:0] addr, D_in_IO;
   wire  [31:0] D_out_IO;
   wire         intr;

   int n_total = 0;
   int n_pass  = 0;

   io_timer_intr #(.ADDR_BASE(12'h100)) dut (
      .clk      (clk),
      .reset    (reset),
      .io_cs    (io_cs),
      .io_rd    (io_rd),
      .io_wr    (io_wr),
      .addr     (addr),
      .D_in_IO  (D_in_IO),
      .D_out_IO (D_out_IO),
      .intr     (intr),
      .int_ack  (int_ack)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic        cs, rd, wr, ack;
      logic [11:0] a;
      logic [31:0] wd;
      logic        chk;
      logic        zexp;
      logic [31:0] ed;
      logic        ei;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t rd_v(logic [11:0] a, logic [31:0] ed, logic ei, logic ack = 1'b0);
      vec_t v;
      v.cs = 1'b1; v.rd = 1'b1; v.wr = 1'b0; v.ack = ack; v.a = a; v.wd = 32'd0;
      v.chk = 1'b1; v.zexp = 1'b0; v.ed = ed; v.ei = ei;
      return v;
   endfunction

   function automatic vec_t wr_v(logic [11:0] a, logic [31:0] wd, logic ei, logic ack = 1'b0);
      vec_t v;
      v.cs = 1'b1; v.rd = 1'b0; v.wr = 1'b1; v.ack = ack; v.a = a; v.wd = wd;
      v.chk = 1'b0; v.zexp = 1'b0; v.ed = 32'd0; v.ei = ei;
      return v;
   endfunction

   function automatic vec_t z_v(logic cs, logic [11:0] a, logic ei);
      vec_t v;
      v.cs = cs; v.rd = 1'b1; v.wr = 1'b0; v.ack = 1'b0; v.a = a; v.wd = 32'd0;
      v.chk = 1'b1; v.zexp = 1'b1; v.ed = 32'd0; v.ei = ei;
      return v;
   endfunction

   function automatic vec_t idle_v(logic ack, logic ei);
      vec_t v;
      v.cs = 1'b0; v.rd = 1'b0; v.wr = 1'b0; v.ack = ack; v.a = 12'h000; v.wd = 32'd0;
      v.chk = 1'b0; v.zexp = 1'b0; v.ed = 32'd0; v.ei = ei;
      return v;
   endfunction

   task automatic chk32(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s[%0d]: D_out_IO=%h want %h", nm, idx, act, exp);
      else n_pass++;
   endtask

   // a released bus reads as all-zero on two-state simulators
   task automatic chkz(input string nm, input int idx, input logic [31:0] act);
      n_total++;
      if (act === 32'hzzzz_zzzz || act === 32'h0000_0000) n_pass++;
      else $display("FAIL %s[%0d]: D_out_IO=%h want zzzzzzzz", nm, idx, act);
   endtask

   task automatic chk1(input string nm, input int idx, input logic act, input logic exp);
      n_total++;
      if (act !== exp) $display("FAIL %s[%0d]: intr=%b want %b", nm, idx, act, exp);
      else n_pass++;
   endtask

   task automatic bus_idle();
      io_cs = 1'b0; io_rd = 1'b0; io_wr = 1'b0; addr = 32'd0; D_in_IO = 32'd0;
   endtask

   // drive one bus cycle from posedge+1, sample at the falling edge, then clock
   task automatic apply(input string nm, input int idx, input vec_t v);
      io_cs = v.cs; io_rd = v.rd; io_wr = v.wr; int_ack = v.ack;
      addr = {20'd0, v.a}; D_in_IO = v.wd;
      #9;
      if (v.chk) begin
         if (v.zexp) chkz(nm, idx, D_out_IO);
         else        chk32(nm, idx, D_out_IO, v.ed);
      end
      chk1({nm, "_intr"}, idx, intr, v.ei);
      @(posedge clk);
      #1;
   endtask

   task automatic rd_now(input string nm, input int idx, input logic [11:0] a, input logic [31:0] exp);
      io_cs = 1'b1; io_rd = 1'b1; io_wr = 1'b0; addr = {20'd0, a};
      #1;
      chk32(nm, idx, D_out_IO, exp);
   endtask

   initial begin
      // one-shot countdown
      vecs.push_back(rd_v(CT, 32'd0, 1'b0));
      vecs.push_back(rd_v(LD, 32'd0, 1'b0));
      vecs.push_back(rd_v(CN, 32'd0, 1'b0));
      vecs.push_back(rd_v(ST, 32'd0, 1'b0));
      vecs.push_back(wr_v(LD, 32'd5, 1'b0));
      vecs.push_back(wr_v(CT, 32'd1, 1'b0));
      vecs.push_back(rd_v(CN, 32'd5, 1'b0));
      vecs.push_back(rd_v(CN, 32'd4, 1'b0));
      vecs.push_back(rd_v(CN, 32'd3, 1'b0));
      vecs.push_back(rd_v(CN, 32'd2, 1'b0));
      vecs.push_back(rd_v(CN, 32'd1, 1'b0));
      vecs.push_back(rd_v(CN, 32'd0, 1'b1));
      vecs.push_back(rd_v(CT, 32'd0, 1'b1));
      vecs.push_back(rd_v(ST, 32'd1, 1'b1));
      // handshake with ack held; event during ACKD only sets OVF
      vecs.push_back(rd_v(ST, 32'd1, 1'b1, 1'b1));
      vecs.push_back(wr_v(LD, 32'd1, 1'b0, 1'b1));
      vecs.push_back(wr_v(CT, 32'd1, 1'b0, 1'b1));
      vecs.push_back(rd_v(CN, 32'd1, 1'b0, 1'b1));
      vecs.push_back(rd_v(ST, 32'd2, 1'b0, 1'b0));
      vecs.push_back(rd_v(ST, 32'd2, 1'b0));
      vecs.push_back(wr_v(ST, 32'd2, 1'b0));
      vecs.push_back(rd_v(ST, 32'd0, 1'b0));
      // ack in IDLE ignored; fresh event accepted
      vecs.push_back(wr_v(CT, 32'd1, 1'b0, 1'b1));
      vecs.push_back(rd_v(CN, 32'd1, 1'b0, 1'b1));
      vecs.push_back(rd_v(ST, 32'd1, 1'b1, 1'b0));
      vecs.push_back(idle_v(1'b1, 1'b1));
      vecs.push_back(idle_v(1'b0, 1'b0));
      vecs.push_back(rd_v(ST, 32'd0, 1'b0));
      // address decode
      vecs.push_back(wr_v(LD, 32'hDEAD_BEEF, 1'b0));
      vecs.push_back(wr_v(CN, 32'hDEAD_BEEF, 1'b0));
      vecs.push_back(rd_v(LD, 32'hDEAD_BEEF, 1'b0));
      vecs.push_back(rd_v(CN, 32'd0, 1'b0));
      vecs.push_back(z_v(1'b1, 12'h110, 1'b0));
      vecs.push_back(z_v(1'b0, LD, 1'b0));
      vecs.push_back(rd_v(12'h107, 32'hDEAD_BEEF, 1'b0));
      vecs.push_back(z_v(1'b1, 12'h204, 1'b0));
      vecs.push_back(rd_v(CT, 32'd0, 1'b0));
      // auto-reload, never acked: overflow sticky, W1C on bit1
      vecs.push_back(wr_v(LD, 32'd3, 1'b0));
      vecs.push_back(wr_v(CT, 32'd3, 1'b0));
      vecs.push_back(rd_v(CN, 32'd3, 1'b0));
      vecs.push_back(rd_v(CN, 32'd2, 1'b0));
      vecs.push_back(rd_v(CN, 32'd1, 1'b0));
      vecs.push_back(rd_v(CN, 32'd3, 1'b1));
      vecs.push_back(rd_v(CN, 32'd2, 1'b1));
      vecs.push_back(rd_v(CN, 32'd1, 1'b1));
      vecs.push_back(rd_v(ST, 32'd3, 1'b1));
      vecs.push_back(wr_v(ST, 32'd2, 1'b1));
      vecs.push_back(rd_v(ST, 32'd1, 1'b1));
      vecs.push_back(rd_v(ST, 32'd3, 1'b1));
      vecs.push_back(wr_v(CT, 32'd0, 1'b1));
      vecs.push_back(rd_v(CN, 32'd1, 1'b1));
      vecs.push_back(rd_v(CT, 32'd0, 1'b1));
      vecs.push_back(wr_v(ST, 32'd2, 1'b1, 1'b1));
      vecs.push_back(idle_v(1'b0, 1'b0));
      vecs.push_back(rd_v(ST, 32'd0, 1'b0));
      // LOAD write on the reload edge reloads the old value
      vecs.push_back(wr_v(LD, 32'd2, 1'b0));
      vecs.push_back(wr_v(CT, 32'd3, 1'b0));
      vecs.push_back(rd_v(CN, 32'd2, 1'b0));
      vecs.push_back(wr_v(LD, 32'd9, 1'b0));
      vecs.push_back(rd_v(CN, 32'd2, 1'b1));
      vecs.push_back(rd_v(CN, 32'd1, 1'b1));
      vecs.push_back(rd_v(CN, 32'd9, 1'b1));
      vecs.push_back(rd_v(ST, 32'd3, 1'b1));

      // initial reset, bus released
      reset = 1'b1;
      int_ack = 1'b0;
      bus_idle();
      #15;
      chkz("rst_bus", 0, D_out_IO);
      chk1("rst_intr", 0, intr, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         apply("vec", i, vecs[i]);
      end
      bus_idle();
      int_ack = 1'b0;

      // async reset pulse between edges while intr is high
      chk1("pre_rst_intr", 0, intr, 1'b1);
      reset = 1'b1;
      #1;
      chk1("async_rst_intr", 0, intr, 1'b0);
      rd_now("rst_rd_ctrl", 0, CT, 32'd0);
      rd_now("rst_rd_count", 0, CN, 32'd0);
      io_cs = 1'b0;
      #1;
      chkz("rst_rd_nocs", 0, D_out_IO);
      reset = 1'b0;
      #1;
      rd_now("post_rst", 0, CT, 32'd0);
      rd_now("post_rst", 1, LD, 32'd0);
      rd_now("post_rst", 2, CN, 32'd0);
      rd_now("post_rst", 3, ST, 32'd0);
      // first edge after release performs a write
      io_rd = 1'b0; io_wr = 1'b1; addr = {20'd0, LD}; D_in_IO = 32'd7;
      @(posedge clk);
      #1;
      io_wr = 1'b0;
      rd_now("first_edge_load", 0, LD, 32'd7);
      chk1("first_edge_intr", 0, intr, 1'b0);
      @(posedge clk);
      #1;

      // CTRL write on the event edge: written value wins, event still fires
      apply("ctl_col", 0, wr_v(LD, 32'd2, 1'b0));
      apply("ctl_col", 1, wr_v(CT, 32'd1, 1'b0));
      apply("ctl_col", 2, rd_v(CN, 32'd2, 1'b0));
      apply("ctl_col", 3, wr_v(CT, 32'd3, 1'b0));
      apply("ctl_col", 4, rd_v(CT, 32'd3, 1'b1));
      apply("ctl_col", 5, rd_v(CN, 32'd0, 1'b1));
      apply("ctl_col", 6, rd_v(ST, 32'd1, 1'b1));

      // OVF clear on the same edge as a new overflow keeps OVF set
      apply("ovf_col", 0, wr_v(LD, 32'd1, 1'b1));
      apply("ovf_col", 1, wr_v(CT, 32'd0, 1'b1));
      apply("ovf_col", 2, wr_v(CT, 32'd3, 1'b1));
      apply("ovf_col", 3, rd_v(CN, 32'd1, 1'b1));
      apply("ovf_col", 4, rd_v(ST, 32'd3, 1'b1));
      apply("ovf_col", 5, wr_v(ST, 32'd2, 1'b1));
      apply("ovf_col", 6, rd_v(ST, 32'd3, 1'b1));
      apply("ovf_col", 7, wr_v(CT, 32'd0, 1'b1));
      apply("ovf_col", 8, wr_v(ST, 32'd2, 1'b1));
      apply("ovf_col", 9, rd_v(ST, 32'd1, 1'b1));
      apply("ovf_col", 10, rd_v(CN, 32'd1, 1'b1));
      bus_idle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
